// File: rtl/nios2_ram_stream_pkg.sv
// Shared types and default widths for the RAM stream reader.
//   RS_ADDR_W / RS_DATA_W : default RAM word-address and data widths
//   RS_BE_W               : RAM byte-enable width
//   rs_state_t            : reader control states
package nios2_ram_stream_pkg;

  localparam int unsigned RS_ADDR_W = 17;
  localparam int unsigned RS_DATA_W = 32;
  localparam int unsigned RS_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rs_state_t;

endpackage

// File: rtl/nios2_ram_stream_fifo.sv
// Synchronous FIFO buffering RAM read data ahead of the stream source.
//   clk, reset_n : clock, async active-low reset (clears contents and pointers)
//   push, push_data : write port (ignored when full)
//   pop          : read port (ignored when empty)
//   head_c       : current head entry, valid while not empty
//   full, empty  : registered status flags
//   count        : registered occupancy
module nios2_ram_stream_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_c  = mem[rd_ptr];

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count;
    if (do_push && !do_pop) count_d = count + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count - CNT_W'(1);
  end

  // Storage, pointers and status flags; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      empty <= (count_d == CNT_W'(0));
      full  <= (count_d == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/nios2_ram_stream_reader.sv
// Reads a block of consecutive words from a latency-1 single-port RAM and
// presents them in address order on a ready/valid stream.
//   clk, reset_n      : clock, async active-low reset
//   start, start_addr, word_count : transfer request (sampled together, ignored while busy)
//   busy, done        : transfer in progress / one-cycle completion pulse
//   ram_*             : read-only RAM master (address, chipselect, constant write/byteenable/clken)
//   src_*             : stream source, src_last marks the final word
module nios2_ram_stream_reader
  import nios2_ram_stream_pkg::*;
#(
  parameter int unsigned ADDR_W     = RS_ADDR_W,
  parameter int unsigned DATA_W     = RS_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [RS_BE_W-1:0]  ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_last
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FILL_W = OCC_W + 1;
  localparam int unsigned ENT_W  = DATA_W + 1;

  rs_state_t          state_q, state_d;
  logic               cs_q, cs_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;     // reads still to be issued
  logic               last_q, last_d;   // the read issued this cycle is the final one
  logic               busy_d, done_d;
  logic               cap_q;            // read data on ram_readdata this cycle
  logic               cap_last_q;

  logic [ENT_W-1:0]   head_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [OCC_W-1:0]   fifo_count;
  logic [FILL_W-1:0]  fill_c;
  logic               room_c;
  logic               accept_c;

  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;
  assign ram_address    = addr_q;
  assign ram_chipselect = cs_q;

  assign src_valid = ~fifo_empty;
  assign src_data  = head_c[DATA_W-1:0];
  assign src_last  = ~fifo_empty & head_c[DATA_W];
  assign accept_c  = src_valid & src_ready;

  // Slots committed: buffered words plus both reads still in the pipe. Ignoring
  // the current pop keeps src_ready out of the issue decision.
  assign fill_c = FILL_W'(fifo_count) + FILL_W'(cap_q) + FILL_W'(cs_q);
  assign room_c = ~fifo_full & (fill_c < FILL_W'(FIFO_DEPTH));

  nios2_ram_stream_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cap_q),
    .push_data ({cap_last_q, ram_readdata}),
    .pop       (accept_c),
    .head_c    (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    addr_d  = addr_q;
    rem_d   = rem_q;
    last_d  = 1'b0;
    busy_d  = busy_q_c();
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count == CNT_W'(0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
            busy_d  = 1'b1;
            cs_d    = 1'b1;
            addr_d  = start_addr;
            rem_d   = word_count - CNT_W'(1);
            last_d  = (word_count == CNT_W'(1));
          end
        end
      end
      ST_READ: begin
        if (cs_q && last_q) begin
          state_d = ST_DRAIN;
        end else if ((rem_q != CNT_W'(0)) && room_c) begin
          cs_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - CNT_W'(1);
          last_d = (rem_q == CNT_W'(1));
        end
      end
      ST_DRAIN: begin
        if (accept_c && src_last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  function automatic logic busy_q_c();
    return busy;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cs_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      last_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      last_q     <= last_d;
      busy       <= busy_d;
      done       <= done_d;
      cap_q      <= cs_q;
      cap_last_q <= cs_q & last_q;
    end
  end

endmodule

// File: tb/tb_nios2_ram_stream_reader.sv
// Self-checking bench for nios2_ram_stream_reader: table of directed transfers,
// randomized transfers, and hand-written zero-length / reset / restart sequences.
module tb_nios2_ram_stream_reader;

  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W:0]     word_count;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic [3:0]          ram_byteenable;
  logic                ram_clken;
  logic [DATA_W-1:0]   ram_readdata;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;
  logic                src_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  nios2_ram_stream_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .start_addr     (start_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_last       (src_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unique content per RAM address.
  function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
    return {a[15:0], ~a[16:1]} ^ 32'hA5C3_0000;
  endfunction

  // Latency-1 RAM; garbage when not selected so mistimed captures show up.
  always @(posedge clk) begin
    if (ram_chipselect) ram_readdata <= ram_word(ram_address);
    else                ram_readdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cs"}, 64'(ram_chipselect), 64'd0);
    chk({tag, "_addr"}, 64'(ram_address), 64'd0);
    chk({tag, "_valid"}, 64'(src_valid), 64'd0);
    chk({tag, "_last"}, 64'(src_last), 64'd0);
    chk({tag, "_data"}, 64'(src_data), 64'd0);
  endtask

  // Run one transfer and check it against the address-order model.
  // mode 0: ready always high, 1: random ready, 2: ready low for 10 cycles then high.
  // restart >= 0 drives a second start at that cycle offset; abort_after > 0 returns
  // once that many words have been taken.
  task automatic run_transfer(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n,
                              input int mode, input int restart, input int abort_after,
                              output logic [ADDR_W-1:0] last_addr);
    int  issued, accepted, s_cyc, last_acc;
    bit  seen_v, fin;
    logic pv, pr, pl;
    logic [DATA_W-1:0] pd;
    issued = 0; accepted = 0; last_acc = -10; seen_v = 0; fin = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; last_addr = '0;
    @(negedge clk);
    start = 1'b1; start_addr = a; word_count = n;
    @(posedge clk);
    #1;
    s_cyc = cyc;
    start = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      if (ram_chipselect) begin
        chk("rd_addr", 64'(ram_address), 64'(ADDR_W'(a + ADDR_W'(issued))));
        issued++;
        last_addr = ram_address;
        chk("rd_count", 64'(issued <= int'(n)), 64'd1);
        chk("rd_bound", 64'((issued - accepted) <= int'(FIFO_DEPTH)), 64'd1);
      end
      if (pv && !pr) begin
        chk("hold_valid", 64'(src_valid), 64'd1);
        chk("hold_data", 64'(src_data), 64'(pd));
        chk("hold_last", 64'(src_last), 64'(pl));
      end
      if (src_valid && !seen_v) begin
        seen_v = 1;
        chk("latency", 64'(cyc - s_cyc), 64'd2);
      end
      case (mode)
        0:       src_ready = 1'b1;
        1:       src_ready = ($urandom_range(0, 3) != 0);
        default: src_ready = (k >= 10);
      endcase
      if (mode == 2 && k == 10) chk("stall_reads", 64'(issued <= int'(FIFO_DEPTH)), 64'd1);
      if (k == restart) begin
        start = 1'b1; start_addr = 17'h05555; word_count = 18'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        chk("done_time", 64'(cyc), 64'(last_acc + 1));
        chk("done_words", 64'(accepted), 64'(n));
        chk("done_busy", 64'(busy), 64'd0);
        fin = 1;
      end else begin
        chk("busy", 64'(busy), 64'd1);
      end
      if (src_valid && src_ready) begin
        chk("data", 64'(src_data), 64'(ram_word(ADDR_W'(a + ADDR_W'(accepted)))));
        chk("last", 64'(src_last), 64'(accepted == int'(n) - 1));
        accepted++;
        last_acc = cyc;
        if (abort_after > 0 && accepted == abort_after) return;
      end
      pv = src_valid; pr = src_ready; pl = src_last; pd = src_data;
    end
    start = 1'b0;
    if (!fin) chk("timeout", 64'd0, 64'd1);
    // After completion nothing further should happen.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_done", 64'({done, busy, ram_chipselect, src_valid}), 64'd0);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    int                mode;
    int                restart;
    logic [ADDR_W-1:0] exp_last_addr;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [ADDR_W-1:0] la;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W:0]   rn;

    vecs[0] = '{17'h00010, 18'd8,  0, -1, 17'h00017};
    vecs[1] = '{17'h1FFFE, 18'd4,  0, -1, 17'h00001};
    vecs[2] = '{17'h00200, 18'd16, 2, -1, 17'h0020F};
    vecs[3] = '{17'h00040, 18'd5,  0,  3, 17'h00044};
    vecs[4] = '{17'h1FFFF, 18'd1,  1, -1, 17'h1FFFF};
    vecs[5] = '{17'h00300, 18'd12, 1, -1, 17'h0030B};

    reset_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; src_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("tie_write", 64'(ram_write), 64'd0);
    chk("tie_be", 64'(ram_byteenable), 64'hF);
    chk("tie_clken", 64'(ram_clken), 64'd1);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_transfer(vecs[i].addr, vecs[i].cnt, vecs[i].mode, vecs[i].restart, 0, la);
      chk($sformatf("vec%0d_last_addr", i), 64'(la), 64'(vecs[i].exp_last_addr));
    end

    // Zero-length request: no reads, busy stays low, done the following cycle only.
    @(negedge clk);
    start = 1'b1; start_addr = 17'h00123; word_count = '0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("zero_cs", 64'(ram_chipselect), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_done", 64'(done), 64'(k == 0));
    end

    // Reset after 3 of 10 words, then a fresh short transfer.
    run_transfer(17'h00080, 18'd10, 0, -1, 3, la);
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    run_transfer(17'h00100, 18'd2, 0, -1, 0, la);
    chk("post_reset_last_addr", 64'(la), 64'h00101);

    // Randomized transfers.
    for (int t = 0; t < 20; t++) begin
      ra = ADDR_W'($urandom);
      rn = (ADDR_W+1)'($urandom_range(1, 24));
      run_transfer(ra, rn, 1, -1, 0, la);
      chk("rand_last_addr", 64'(la), 64'(ADDR_W'(ra + ADDR_W'(rn) - ADDR_W'(1))));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
